// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals and the region type used by the
// horizontal and vertical decoders of the sync pipeline.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_RD_LAT   = 2;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int COUNT_W = 10;
    localparam int ADDR_W  = 19;

    typedef enum logic [1:0] {
        R_ACT,
        R_FRONT,
        R_SYNC,
        R_BACK
    } region_t;

    // Positions past the back porch (bad upstream counts) fall into R_BACK.
    function automatic region_t decode_region(input int pos, input int active,
                                              input int fp, input int sync);
        if (pos < active)             return R_ACT;
        if (pos < active + fp)        return R_FRONT;
        if (pos < active + fp + sync) return R_SYNC;
        return R_BACK;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// En-qualified shift register that carries the timing flags alongside the
// framebuffer read latency; every stage resets to all-zero (inactive).
module vga_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else if (en) begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/vga_sync_pipe.sv
// VGA sync/pixel stage: decodes upstream counts, issues framebuffer reads and
// delays syncs/de/frame_start so they line up with the returned pixel data.
module vga_sync_pipe
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int RD_LAT   = DEF_RD_LAT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [COUNT_W-1:0] h_count,
    input  logic [COUNT_W-1:0] v_count,
    output logic               fb_rd_en,
    output logic [ADDR_W-1:0]  fb_rd_addr,
    input  logic [11:0]        fb_rd_data,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               vga_hs_n,
    output logic               vga_vs_n,
    output logic               vga_de,
    output logic               frame_start,
    output logic               count_err
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    region_t h_state, h_next, v_state, v_next;
    logic               hs0, vs0;
    logic               at_origin, pixel_active, synced, frame_q;
    logic [ADDR_W-1:0]  addr_cnt;
    logic               have_prev, seq_bad;
    logic [COUNT_W-1:0] prev_h, exp_h;
    logic [3:0]         dl_d, dl_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_state <= R_BACK;
            v_state <= R_BACK;
        end else begin
            h_state <= h_next;
            v_state <= v_next;
        end
    end

    always_comb begin
        h_next = h_state;
        v_next = v_state;
        if (en) begin
            h_next = decode_region(int'(h_count), H_ACTIVE, H_FP, H_SYNC);
            v_next = decode_region(int'(v_count), V_ACTIVE, V_FP, V_SYNC);
        end
    end

    always_comb begin
        hs0 = (h_state == R_SYNC);
        vs0 = (v_state == R_SYNC);
    end

    // Pixels are only fetched once a (0,0) has realigned the address counter.
    assign at_origin    = (h_count == '0) && (v_count == '0);
    assign pixel_active = en && (h_next == R_ACT) && (v_next == R_ACT) && (synced || at_origin);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb_rd_en   <= 1'b0;
            fb_rd_addr <= '0;
            addr_cnt   <= '0;
            frame_q    <= 1'b0;
            synced     <= 1'b0;
        end else if (en) begin
            fb_rd_en <= pixel_active;
            frame_q  <= at_origin;
            if (at_origin) begin
                synced     <= 1'b1;
                fb_rd_addr <= '0;
                addr_cnt   <= ADDR_W'(1);
            end else if (pixel_active) begin
                fb_rd_addr <= addr_cnt;
                addr_cnt   <= addr_cnt + ADDR_W'(1);
            end
        end
    end

    assign exp_h   = (int'(prev_h) == H_TOTAL - 1) ? '0 : prev_h + COUNT_W'(1);
    assign seq_bad = (int'(h_count) > H_TOTAL - 1) ||
                     (int'(v_count) > V_TOTAL - 1) ||
                     (have_prev && (h_count != exp_h));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_err <= 1'b0;
            have_prev <= 1'b0;
            prev_h    <= '0;
        end else if (en) begin
            have_prev <= 1'b1;
            prev_h    <= h_count;
            if (seq_bad) count_err <= 1'b1;
        end
    end

    assign dl_d = {hs0, vs0, fb_rd_en, frame_q};

    vga_delay_line #(
        .WIDTH(4),
        .DEPTH(RD_LAT)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .d       (dl_d),
        .q       (dl_q)
    );

    assign vga_hs_n    = ~dl_q[3];
    assign vga_vs_n    = ~dl_q[2];
    assign vga_de      = dl_q[1];
    assign frame_start = dl_q[0];
    assign vga_r       = vga_de ? fb_rd_data[11:8] : 4'h0;
    assign vga_g       = vga_de ? fb_rd_data[7:4]  : 4'h0;
    assign vga_b       = vga_de ? fb_rd_data[3:0]  : 4'h0;

endmodule

// File: tb/tb_vga_sync_pipe.sv
// Bench for vga_sync_pipe on a reduced raster, with a latency-RD_LAT framebuffer
// model and a rule-based reference for syncs, de, pixels, addresses and errors.
module tb_vga_sync_pipe;

    localparam int HA = 20, HFP = 3, HS = 5, HB = 4;
    localparam int VA = 6,  VFP = 2, VS = 2, VB = 3;
    localparam int LAT  = 2;
    localparam int HT   = HA + HFP + HS + HB;
    localparam int VT   = VA + VFP + VS + VB;
    localparam int NPIX = HA * VA;

    logic        clk = 1'b0;
    logic        reset_n, en;
    logic [9:0]  h_count, v_count;
    logic        fb_rd_en;
    logic [18:0] fb_rd_addr;
    logic [11:0] fb_rd_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs_n, vga_vs_n, vga_de, frame_start, count_err;

    always #5 clk = ~clk;

    vga_sync_pipe #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .RD_LAT(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .h_count(h_count), .v_count(v_count),
        .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs_n(vga_hs_n), .vga_vs_n(vga_vs_n), .vga_de(vga_de),
        .frame_start(frame_start), .count_err(count_err)
    );

    logic [11:0] mem [NPIX];
    logic [11:0] fb_pipe [LAT];

    function automatic logic [11:0] fb_word(input int a);
        if (a >= 0 && a < NPIX) return mem[a];
        return 12'h000;
    endfunction

    // Framebuffer: a request seen on an en-cycle returns LAT en-cycles later.
    always @(posedge clk) begin
        if (en) begin
            fb_pipe[0] <= fb_rd_en ? fb_word(int'(fb_rd_addr)) : 12'h000;
            for (int i = 1; i < LAT; i++) fb_pipe[i] <= fb_pipe[i-1];
        end
    end
    assign fb_rd_data = fb_pipe[LAT-1];

    typedef struct packed {
        logic        hs_n;
        logic        vs_n;
        logic        de;
        logic [11:0] rgb;
        logic        fs;
    } out_t;

    localparam out_t BLANK = '{hs_n: 1'b1, vs_n: 1'b1, de: 1'b0, rgb: 12'h000, fs: 1'b0};

    int   pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    out_t exp_q[$];
    out_t last_out;
    bit   m_synced, m_have_prev, m_err, pos_ok;
    int   m_prev_h, m_rd_count, since_origin;
    int   de_cnt, hs_cnt, vs_cnt;
    logic [11:0] pix_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < LAT; i++) exp_q.push_back(BLANK);
        last_out     = BLANK;
        m_synced     = 1'b0;
        m_have_prev  = 1'b0;
        m_err        = 1'b0;
        pos_ok       = 1'b0;
        m_prev_h     = 0;
        m_rd_count   = 0;
        since_origin = 1000;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hs_n"},  32'(vga_hs_n), 32'd1);
        check({tag, "_vs_n"},  32'(vga_vs_n), 32'd1);
        check({tag, "_de"},    32'(vga_de), 32'd0);
        check({tag, "_rgb"},   32'({vga_r, vga_g, vga_b}), 32'd0);
        check({tag, "_rd_en"}, 32'(fb_rd_en), 32'd0);
        check({tag, "_addr"},  32'(fb_rd_addr), 32'd0);
        check({tag, "_fs"},    32'(frame_start), 32'd0);
        check({tag, "_err"},   32'(count_err), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 check_reset(tag);
        model_reset();
        @(negedge clk) reset_n = 1'b1;
    endtask

    // One clock: drive counts, clock, then compare against the rule-based model.
    task automatic step(input logic e, input int h, input int v);
        out_t rec;
        bit   origin, active, bad;
        en      = e;
        h_count = 10'(h);
        v_count = 10'(v);
        @(posedge clk);
        #1;
        if (e) begin
            origin = (h == 0) && (v == 0);
            bad = (h > HT - 1) || (v > VT - 1) ||
                  (m_have_prev && (h != (m_prev_h + 1) % HT));
            if (bad) begin
                m_err  = 1'b1;
                pos_ok = 1'b0;
            end
            m_have_prev = 1'b1;
            m_prev_h    = h;
            if (origin) begin
                m_synced     = 1'b1;
                m_rd_count   = 0;
                pos_ok       = 1'b1;
                since_origin = 0;
            end else begin
                since_origin++;
            end
            active   = m_synced && (h < HA) && (v < VA);
            rec.hs_n = !((h >= HA + HFP) && (h < HA + HFP + HS));
            rec.vs_n = !((v >= VA + VFP) && (v < VA + VFP + VS));
            rec.de   = active;
            rec.rgb  = active ? fb_word(m_rd_count) : 12'h000;
            rec.fs   = origin;
            check("rd_en", 32'(fb_rd_en), 32'(active));
            if (active) begin
                check("rd_addr", 32'(fb_rd_addr), 32'(m_rd_count));
                if (pos_ok && h == 0 && v == 0)           check("addr_first", 32'(fb_rd_addr), 32'd0);
                if (pos_ok && h == HA - 1 && v == 0)      check("addr_line0_end", 32'(fb_rd_addr), 32'(HA - 1));
                if (pos_ok && h == 0 && v == 1)           check("addr_line1_start", 32'(fb_rd_addr), 32'(HA));
                if (pos_ok && h == HA - 1 && v == VA - 1) check("addr_last", 32'(fb_rd_addr), 32'(NPIX - 1));
                m_rd_count++;
            end
            exp_q.push_back(rec);
            last_out = exp_q.pop_front();
        end
        check("pixel", 32'({vga_hs_n, vga_vs_n, vga_de, vga_r, vga_g, vga_b, frame_start}), 32'(last_out));
        check("count_err", 32'(count_err), 32'(m_err));
        if (e) begin
            if (pos_ok && since_origin == LAT - 1) check("lat_fs_early", 32'(frame_start), 32'd0);
            if (pos_ok && since_origin == LAT) begin
                check("lat_fs", 32'(frame_start), 32'd1);
                check("lat_rgb", 32'({vga_r, vga_g, vga_b}), 32'(fb_word(0)));
            end
            if (vga_de) begin
                de_cnt++;
                pix_q.push_back({vga_r, vga_g, vga_b});
            end
            if (!vga_hs_n) hs_cnt++;
            if (!vga_vs_n) vs_cnt++;
        end
    endtask

    task automatic run_counts(input int start_h, input int start_v, input int n, input bit toggle);
        int h, v;
        h = start_h;
        v = start_v;
        for (int i = 0; i < n; i++) begin
            if (toggle && $urandom_range(0, 1) == 1)
                step(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            step(1'b1, h, v);
            h++;
            if (h == HT) begin
                h = 0;
                v = (v == VT - 1) ? 0 : v + 1;
            end
        end
    endtask

    task automatic run_frame(input bit toggle);
        de_cnt = 0;
        hs_cnt = 0;
        vs_cnt = 0;
        pix_q.delete();
        run_counts(0, 0, HT * VT, toggle);
        check("de_per_frame", 32'(de_cnt), 32'(NPIX));
        check("hs_low_per_frame", 32'(hs_cnt), 32'(HS * VT));
        check("vs_low_per_frame", 32'(vs_cnt), 32'(VS * HT));
        check("pix_seq_len", 32'(pix_q.size()), 32'(NPIX));
        for (int i = 0; i < NPIX && i < pix_q.size(); i++)
            check("pix_seq", 32'(pix_q[i]), 32'(fb_word(i)));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        h_count = '0;
        v_count = '0;
        for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);
        mem[0] = 12'hABC;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset("por");
        @(negedge clk) reset_n = 1'b1;

        run_counts(HT - 4, VT - 1, 4, 1'b0);
        run_frame(1'b0);
        run_frame(1'b0);
        run_frame(1'b1);

        // Horizontal jump inside line 0, then the flag must stay set.
        run_counts(0, 0, 11, 1'b0);
        step(1'b1, 12, 0);
        check("err_jump", 32'(count_err), 32'd1);
        run_counts(13, 0, 2 * HT - 13, 1'b0);
        check("err_sticky", 32'(count_err), 32'd1);
        apply_reset("err_clr");

        run_counts(0, 2, 5, 1'b0);
        check("err_clean", 32'(count_err), 32'd0);
        step(1'b1, HT, 2);
        check("err_hrange", 32'(count_err), 32'd1);
        step(1'b1, 0, 3);
        check("err_hrange_sticky", 32'(count_err), 32'd1);
        apply_reset("err_clr2");

        step(1'b1, 0, VT);
        check("err_vrange", 32'(count_err), 32'd1);
        apply_reset("err_clr3");

        // Mid-frame reset: nothing visible until the next (0,0).
        run_counts(0, 0, 3 * HT + 11, 1'b0);
        apply_reset("async_mid");
        de_cnt = 0;
        run_counts(11, 3, HT * VT - (3 * HT + 11), 1'b0);
        check("de_before_origin", 32'(de_cnt), 32'd0);
        run_frame(1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
